// File: rtl/riscv_pkg.sv
// Shared pipeline control definitions: FSM states, jump encoding, control bundle.
package riscv_pkg;

  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned JUMP_W      = 2;
  localparam int unsigned TIMEOUT_W   = 8;
  localparam int unsigned STALL_CNT_W = 16;

  localparam logic [JUMP_W-1:0] JUMP_TAKEN = 2'b11;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_err;
  } ctrl_bus_t;

  // Taken branch or unconditional jump resolved in EX.
  function automatic logic is_redirect(input logic branch_taken,
                                       input logic [JUMP_W-1:0] jump);
    return branch_taken | (jump == JUMP_TAKEN);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  output logic                 load_use
);

  logic rd_live;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real dependency.
  assign rd_live  = ex_mem_read && (ex_rd != REG_IDX_W'(0));
  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use = rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: memory-wait stalls with timeout, redirect
// flushes and load-use bubbles, plus a saturating stall-cycle counter.
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_IDX_W-1:0]   id_rs1,
  input  logic [REG_IDX_W-1:0]   id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REG_IDX_W-1:0]   ex_rd,
  input  logic                   ex_mem_read,
  input  logic [JUMP_W-1:0]      ex_jump,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_stall,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e          state;
  ctrl_state_e          state_nxt;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [TIMEOUT_W-1:0] wait_cnt_nxt;
  ctrl_bus_t            ctrl;
  logic                 load_use;
  logic                 redirect;
  logic                 mem_wait;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign redirect = is_redirect(ex_branch_taken, ex_jump);
  assign mem_wait = mem_req && !mem_ready;

  // State and timeout counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state and control outputs; reset forces every control low.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    ctrl         = '0;

    case (state)
      RUN, FLUSH: begin
        if (mem_wait) begin
          ctrl.pc_stall     = 1'b1;
          ctrl.if_id_stall  = 1'b1;
          ctrl.ex_mem_stall = 1'b1;
          state_nxt         = MEM_WAIT;
          wait_cnt_nxt      = '0;
        end else if (redirect) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_flush  = 1'b1;
          state_nxt         = FLUSH;
        end else if (state == FLUSH) begin
          // Squash the wrong-path fetch that arrived behind the redirect.
          ctrl.if_id_flush  = 1'b1;
          state_nxt         = RUN;
        end else if (load_use) begin
          ctrl.pc_stall     = 1'b1;
          ctrl.if_id_stall  = 1'b1;
          ctrl.id_ex_flush  = 1'b1;
        end
      end

      MEM_WAIT: begin
        ctrl.pc_stall     = 1'b1;
        ctrl.if_id_stall  = 1'b1;
        ctrl.ex_mem_stall = 1'b1;
        if (mem_ready) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          ctrl.mem_err = 1'b1;
          state_nxt    = RUN;
        end else begin
          wait_cnt_nxt = wait_cnt + TIMEOUT_W'(1);
        end
      end

      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    if (reset) begin
      ctrl = '0;
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_stall = ctrl.ex_mem_stall;
  assign mem_err      = ctrl.mem_err;

  // Saturating count of PC-stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (ctrl.pc_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule
